// File: rtl/fp_pkg.sv
// ============================================================================
// Module  : fp_pkg
// Purpose : Shared floating-point constants, operand classes and helpers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_pkg;

    localparam logic [1:0] RM_RNE = 2'd0;
    localparam logic [1:0] RM_RTZ = 2'd1;
    localparam logic [1:0] RM_RUP = 2'd2;
    localparam logic [1:0] RM_RDN = 2'd3;

    localparam int FLG_W         = 5;
    localparam int FLG_INVALID   = 4;
    localparam int FLG_DIVZERO   = 3;
    localparam int FLG_OVERFLOW  = 2;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_INEXACT   = 0;

    localparam int NAN_MAX_W = 128;

    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_INF  = 3'd1,
        CLS_QNAN = 3'd2,
        CLS_SNAN = 3'd3,
        CLS_NORM = 3'd4
    } fp_class_e;

    // Subnormals fold into CLS_ZERO (denormals-are-zero).
    function automatic fp_class_e classify(input logic exp_zero, input logic exp_ones,
                                           input logic frac_zero, input logic frac_msb);
        if (exp_zero)       return CLS_ZERO;
        else if (!exp_ones) return CLS_NORM;
        else if (frac_zero) return CLS_INF;
        else if (frac_msb)  return CLS_QNAN;
        else                return CLS_SNAN;
    endfunction

    function automatic logic [NAN_MAX_W-1:0] canon_nan(input int exp_w, input int man_w);
        logic [NAN_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < exp_w; i++) r[man_w+i] = 1'b1;
        r[man_w-1] = 1'b1;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_round_pack.sv
// ============================================================================
// Module  : fp_round_pack
// Purpose : Combinational round/pack of a normalised significand, with
//           overflow / flush-to-zero handling and exception flags.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_round_pack
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                      sign_i,
    input  logic signed [EXP_W+1:0]   exp_i,
    input  logic [MAN_W:0]            mant_i,
    input  logic                      guard_i,
    input  logic                      sticky_i,
    input  logic [1:0]                rm_i,
    output logic [EXP_W+MAN_W:0]      z_o,
    output logic [FLG_W-1:0]          flags_o
);

    localparam logic signed [EXP_W+1:0] EXP_ONE  = (EXP_W+2)'(1);
    localparam logic signed [EXP_W+1:0] EXP_ZERO = '0;
    localparam logic signed [EXP_W+1:0] EXP_OVF  = (EXP_W+2)'(2**EXP_W - 1);

    logic                    inexact;
    logic                    inc;
    logic [MAN_W+1:0]        sum;
    logic [MAN_W-1:0]        frac_r;
    logic signed [EXP_W+1:0] exp_r;
    logic [EXP_W+MAN_W:0]    inf_z;
    logic [EXP_W+MAN_W:0]    maxf_z;

    always_comb begin
        inexact = guard_i | sticky_i;
        case (rm_i)
            RM_RNE:  inc = guard_i & (sticky_i | mant_i[0]);
            RM_RTZ:  inc = 1'b0;
            RM_RUP:  inc = inexact & ~sign_i;
            default: inc = inexact & sign_i;
        endcase

        sum = {1'b0, mant_i} + {{(MAN_W+1){1'b0}}, inc};
        // Carry-out only happens from an all-ones significand, so the
        // renormalised fraction is simply the upper bits of the sum.
        if (sum[MAN_W+1]) begin
            frac_r = sum[MAN_W:1];
            exp_r  = exp_i + EXP_ONE;
        end else begin
            frac_r = sum[MAN_W-1:0];
            exp_r  = exp_i;
        end

        inf_z  = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        maxf_z = {sign_i, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

        flags_o = '0;
        if (exp_r >= EXP_OVF) begin
            flags_o[FLG_OVERFLOW] = 1'b1;
            flags_o[FLG_INEXACT]  = 1'b1;
            case (rm_i)
                RM_RNE:  z_o = inf_z;
                RM_RTZ:  z_o = maxf_z;
                RM_RUP:  z_o = sign_i ? maxf_z : inf_z;
                default: z_o = sign_i ? inf_z : maxf_z;
            endcase
        end else if (exp_r <= EXP_ZERO) begin
            flags_o[FLG_UNDERFLOW] = 1'b1;
            flags_o[FLG_INEXACT]   = 1'b1;
            z_o = {sign_i, {(EXP_W+MAN_W){1'b0}}};
        end else begin
            flags_o[FLG_INEXACT] = inexact;
            z_o = {sign_i, exp_r[EXP_W-1:0], frac_r};
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp_mul_pipe.sv
// ============================================================================
// Module  : fp_mul_pipe
// Purpose : Three-stage pipelined IEEE-754 multiplier with valid/ready flow
//           control, run-time rounding mode and exception flags.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic [1:0]             in_rm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_z,
    output logic [FLG_W-1:0]       out_flags
);

    localparam int W    = EXP_W + MAN_W + 1;
    localparam int EW   = EXP_W + 2;
    localparam int PW   = 2 * (MAN_W + 1);
    localparam int BIAS = 2**(EXP_W-1) - 1;
    localparam logic [W-1:0]         QNAN    = W'(canon_nan(EXP_W, MAN_W));
    localparam logic signed [EW-1:0] EXP_ONE = EW'(1);

    logic advance;

    // Stage 1 registers
    logic                 v1_q, sign1_q, spc1_q, spc_inv1_q;
    logic [W-1:0]         spc_z1_q;
    logic [PW-1:0]        prod1_q;
    logic signed [EW-1:0] exp1_q;
    logic [1:0]           rm1_q;

    // Stage 2 registers
    logic                 v2_q, sign2_q, spc2_q, spc_inv2_q, guard2_q, sticky2_q;
    logic [W-1:0]         spc_z2_q;
    logic [MAN_W:0]       mant2_q;
    logic signed [EW-1:0] exp2_q;
    logic [1:0]           rm2_q;

    // Output registers
    logic                 out_valid_q;
    logic [W-1:0]         out_z_q;
    logic [FLG_W-1:0]     out_flags_q;

    assign advance   = ~out_valid_q | out_ready;
    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign out_z     = out_z_q;
    assign out_flags = out_flags_q;

    // ---------------- S1: unpack, classify, multiply ----------------
    logic [EXP_W-1:0]     ea, eb;
    logic [MAN_W-1:0]     fa, fb;
    fp_class_e            cls_a, cls_b;
    logic                 nan_a, nan_b, snan_any, inf_a, inf_b, zero_a, zero_b;
    logic                 sign1_d, spc1_d, spc_inv1_d;
    logic [W-1:0]         spc_z1_d;
    logic [PW-1:0]        prod1_d;
    logic signed [EW-1:0] exp1_d;

    always_comb begin
        ea = in_a[W-2:MAN_W];
        eb = in_b[W-2:MAN_W];
        fa = in_a[MAN_W-1:0];
        fb = in_b[MAN_W-1:0];
        cls_a = classify(ea == '0, &ea, fa == '0, fa[MAN_W-1]);
        cls_b = classify(eb == '0, &eb, fb == '0, fb[MAN_W-1]);
        nan_a    = (cls_a == CLS_QNAN) || (cls_a == CLS_SNAN);
        nan_b    = (cls_b == CLS_QNAN) || (cls_b == CLS_SNAN);
        snan_any = (cls_a == CLS_SNAN) || (cls_b == CLS_SNAN);
        inf_a    = (cls_a == CLS_INF);
        inf_b    = (cls_b == CLS_INF);
        zero_a   = (cls_a == CLS_ZERO);
        zero_b   = (cls_b == CLS_ZERO);

        sign1_d    = in_a[W-1] ^ in_b[W-1];
        spc1_d     = 1'b1;
        spc_inv1_d = 1'b0;
        spc_z1_d   = QNAN;
        if (nan_a || nan_b) begin
            spc_inv1_d = snan_any;
        end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
            spc_inv1_d = 1'b1;
        end else if (inf_a || inf_b) begin
            spc_z1_d = {sign1_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (zero_a || zero_b) begin
            spc_z1_d = {sign1_d, {(W-1){1'b0}}};
        end else begin
            spc1_d = 1'b0;
        end

        prod1_d = PW'({1'b1, fa}) * PW'({1'b1, fb});
        exp1_d  = EW'(ea) + EW'(eb) - EW'(BIAS);
    end

    // ---------------- S2: normalise ----------------
    logic [PW-1:0]        pn;
    logic [MAN_W:0]       mant2_d;
    logic                 guard2_d, sticky2_d;
    logic signed [EW-1:0] exp2_d;

    always_comb begin
        pn        = prod1_q[PW-1] ? prod1_q : {prod1_q[PW-2:0], 1'b0};
        mant2_d   = pn[PW-1 -: MAN_W+1];
        guard2_d  = pn[MAN_W];
        sticky2_d = |pn[MAN_W-1:0];
        exp2_d    = prod1_q[PW-1] ? exp1_q + EXP_ONE : exp1_q;
    end

    // ---------------- S3: round, pack, select specials ----------------
    logic [W-1:0]     rp_z;
    logic [FLG_W-1:0] rp_flags;
    logic [FLG_W-1:0] spc_flags;
    logic [W-1:0]     out_z_d;
    logic [FLG_W-1:0] out_flags_d;

    fp_round_pack #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round_pack (
        .sign_i   (sign2_q),
        .exp_i    (exp2_q),
        .mant_i   (mant2_q),
        .guard_i  (guard2_q),
        .sticky_i (sticky2_q),
        .rm_i     (rm2_q),
        .z_o      (rp_z),
        .flags_o  (rp_flags)
    );

    always_comb begin
        spc_flags = '0;
        spc_flags[FLG_INVALID] = spc_inv2_q;
        out_z_d     = '0;
        out_flags_d = '0;
        if (v2_q) begin
            out_z_d     = spc2_q ? spc_z2_q  : rp_z;
            out_flags_d = spc2_q ? spc_flags : rp_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            sign1_q     <= 1'b0;
            spc1_q      <= 1'b0;
            spc_inv1_q  <= 1'b0;
            spc_z1_q    <= '0;
            prod1_q     <= '0;
            exp1_q      <= '0;
            rm1_q       <= '0;
            v2_q        <= 1'b0;
            sign2_q     <= 1'b0;
            spc2_q      <= 1'b0;
            spc_inv2_q  <= 1'b0;
            spc_z2_q    <= '0;
            mant2_q     <= '0;
            guard2_q    <= 1'b0;
            sticky2_q   <= 1'b0;
            exp2_q      <= '0;
            rm2_q       <= '0;
            out_valid_q <= 1'b0;
            out_z_q     <= '0;
            out_flags_q <= '0;
        end else if (advance) begin
            v1_q        <= in_valid;
            sign1_q     <= sign1_d;
            spc1_q      <= spc1_d;
            spc_inv1_q  <= spc_inv1_d;
            spc_z1_q    <= spc_z1_d;
            prod1_q     <= prod1_d;
            exp1_q      <= exp1_d;
            rm1_q       <= in_rm;
            v2_q        <= v1_q;
            sign2_q     <= sign1_q;
            spc2_q      <= spc1_q;
            spc_inv2_q  <= spc_inv1_q;
            spc_z2_q    <= spc_z1_q;
            mant2_q     <= mant2_d;
            guard2_q    <= guard2_d;
            sticky2_q   <= sticky2_d;
            exp2_q      <= exp2_d;
            rm2_q       <= rm1_q;
            out_valid_q <= v2_q;
            out_z_q     <= out_z_d;
            out_flags_q <= out_flags_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fp_mul_pipe.sv
// ============================================================================
// Module  : tb_fp_mul_pipe
// Purpose : Self-checking bench for fp_mul_pipe (binary32) against an
//           exact-integer reference multiplier.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_mul_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [1:0]  in_rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_z;
    logic [4:0]  out_flags;

    int n_pass  = 0;
    int n_total = 0;

    fp_mul_pipe #(
        .EXP_W (8),
        .MAN_W (23)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_rm     (in_rm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_flags (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    // Exact reference: integer significand product, remainder-based rounding.
    // Returns {flags[4:0], z[31:0]}.
    function automatic logic [36:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] rm);
        int ea, eb, msb, sh, e;
        logic [22:0] fa, fb;
        logic s, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, up, inx;
        logic [63:0] p, q, rem, half;
        logic [31:0] inf_z, maxf_z;
        ea = int'(a[30:23]);  eb = int'(b[30:23]);
        fa = a[22:0];         fb = b[22:0];
        s  = a[31] ^ b[31];
        a_nan  = (ea == 255) && (fa != 0);  b_nan  = (eb == 255) && (fb != 0);
        a_snan = a_nan && !fa[22];          b_snan = b_nan && !fb[22];
        a_inf  = (ea == 255) && (fa == 0);  b_inf  = (eb == 255) && (fb == 0);
        a_zero = (ea == 0);                 b_zero = (eb == 0);
        if (a_nan || b_nan) return {a_snan || b_snan, 4'b0000, 32'h7FC00000};
        if ((a_inf && b_zero) || (b_inf && a_zero)) return {5'b10000, 32'h7FC00000};
        if (a_inf || b_inf) return {5'b00000, s, 8'hFF, 23'd0};
        if (a_zero || b_zero) return {5'b00000, s, 31'd0};

        p = 64'({1'b1, fa}) * 64'({1'b1, fb});
        msb = 0;
        for (int i = 0; i < 64; i++) if (p[i]) msb = i;
        sh   = msb - 23;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        inx  = (rem != 0);
        case (rm)
            2'd0:    up = (rem > half) || ((rem == half) && q[0]);
            2'd1:    up = 1'b0;
            2'd2:    up = inx && !s;
            default: up = inx && s;
        endcase
        q = q + 64'(up);
        e = sh + ea + eb - 150;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        inf_z  = {s, 8'hFF, 23'd0};
        maxf_z = {s, 8'hFE, 23'h7FFFFF};
        if (e >= 255) begin
            case (rm)
                2'd0:    return {5'b00101, inf_z};
                2'd1:    return {5'b00101, maxf_z};
                2'd2:    return {5'b00101, s ? maxf_z : inf_z};
                default: return {5'b00101, s ? inf_z : maxf_z};
            endcase
        end
        if (e <= 0) return {5'b00011, s, 31'd0};
        return {4'b0000, inx, s, 8'(e), q[22:0]};
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 11))
            0: r[30:23] = 8'hFF;
            1: r[30:23] = 8'h00;
            2: r[30:23] = 8'($urandom_range(200, 254));
            3: r[30:23] = 8'($urandom_range(1, 40));
            4: r[22:0]  = 23'h7FFFFF;
            5: r[30:23] = 8'($urandom_range(120, 135));
            default: ;
        endcase
        return r;
    endfunction

    // Drive one cycle's inputs at the falling edge and sample handshakes just after.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] rm, input logic ordy,
                        output logic acc, output logic drn);
        @(negedge clk);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_rm     = rm;
        out_ready = ordy;
        #1;
        acc = in_valid & in_ready;
        drn = out_valid & out_ready;
    endtask

    // Issue one operation into an idle pipe; lat counts clock edges from accept to out_valid.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                         output logic [31:0] z, output logic [4:0] f, output int lat);
        logic acc, drn;
        int k;
        acc = 1'b0;
        k = 0;
        while (!acc && k < 20) begin
            step(1'b1, a, b, rm, 1'b1, acc, drn);
            k++;
        end
        lat = -1;
        z = 'x;
        f = 'x;
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 32'd0, 32'd0, 2'd0, 1'b1, acc, drn);
            if (out_valid) begin
                z = out_z;
                f = out_flags;
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        in_valid = 1'b0; in_a = '0; in_b = '0; in_rm = '0; out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_z !== 32'd0) $display("FAIL reset_out_z: got %h want 00000000", out_z); else n_pass++;
        n_total++; if (out_flags !== 5'd0) $display("FAIL reset_out_flags: got %b want 00000", out_flags); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_basic();
        logic [31:0] z; logic [4:0] f; int lat;
        issue(32'h3FC00000, 32'h40000000, 2'd0, z, f, lat);
        n_total++; if (lat !== 3) $display("FAIL basic_latency: got %0d want 3", lat); else n_pass++;
        n_total++; if (z !== 32'h40400000) $display("FAIL basic_z: got %h want 40400000", z); else n_pass++;
        n_total++; if (f !== 5'd0) $display("FAIL basic_flags: got %b want 00000", f); else n_pass++;
    endtask

    task automatic run_table(input string name, input logic [31:0] ta [3], input logic [31:0] tb [3],
                             input logic [1:0] trm [3], input logic [31:0] tz [3], input logic [4:0] tf [3]);
        logic [31:0] z; logic [4:0] f; int lat;
        for (int i = 0; i < 3; i++) begin
            issue(ta[i], tb[i], trm[i], z, f, lat);
            n_total++;
            if (z !== tz[i] || f !== tf[i])
                $display("FAIL %s[%0d]: got z=%h flags=%b want z=%h flags=%b", name, i, z, f, tz[i], tf[i]);
            else n_pass++;
        end
    endtask

    task automatic test_rounding();
        logic [31:0] ta [3], tb [3], tz [3]; logic [1:0] trm [3]; logic [4:0] tf [3];
        ta  = '{32'h3F800001, 32'h3F800001, 32'h3F800001};
        tb  = '{32'h3F800001, 32'h3F800001, 32'h3F800001};
        trm = '{2'd0, 2'd2, 2'd1};
        tz  = '{32'h3F800002, 32'h3F800003, 32'h3F800002};
        tf  = '{5'b00001, 5'b00001, 5'b00001};
        run_table("rounding", ta, tb, trm, tz, tf);
    endtask

    task automatic test_overflow();
        logic [31:0] ta [3], tb [3], tz [3]; logic [1:0] trm [3]; logic [4:0] tf [3];
        ta  = '{32'h7F000000, 32'h7F000000, 32'hFF000000};
        tb  = '{32'h40000000, 32'h40000000, 32'h40000000};
        trm = '{2'd0, 2'd1, 2'd2};
        tz  = '{32'h7F800000, 32'h7F7FFFFF, 32'hFF7FFFFF};
        tf  = '{5'b00101, 5'b00101, 5'b00101};
        run_table("overflow", ta, tb, trm, tz, tf);
    endtask

    task automatic test_specials();
        logic [31:0] ta [3], tb [3], tz [3]; logic [1:0] trm [3]; logic [4:0] tf [3];
        ta  = '{32'h7F800000, 32'h7F800001, 32'h00800000};
        tb  = '{32'h00000000, 32'h3F800000, 32'h00800000};
        trm = '{2'd0, 2'd0, 2'd0};
        tz  = '{32'h7FC00000, 32'h7FC00000, 32'h00000000};
        tf  = '{5'b10000, 5'b10000, 5'b00011};
        run_table("specials", ta, tb, trm, tz, tf);
    endtask

    task automatic test_random();
        logic [31:0] qz [$]; logic [4:0] qf [$];
        logic acc, drn, v, o, held_v;
        logic [31:0] a, b, held_z, ez; logic [4:0] held_f, ef; logic [1:0] rm;
        logic [36:0] e;
        held_v = 1'b0; held_z = '0; held_f = '0;
        for (int c = 0; c < 400; c++) begin
            v  = (c < 360) && ($urandom_range(0, 9) < 7);
            o  = (c >= 360) || ($urandom_range(0, 9) < 6);
            a  = rnd_op();
            b  = rnd_op();
            rm = 2'($urandom_range(0, 3));
            step(v, a, b, rm, o, acc, drn);
            if (held_v) begin
                n_total++;
                if (out_valid !== 1'b1 || out_z !== held_z || out_flags !== held_f)
                    $display("FAIL random_stall_hold: got v=%b z=%h f=%b want v=1 z=%h f=%b",
                             out_valid, out_z, out_flags, held_z, held_f);
                else n_pass++;
            end
            n_total++;
            if (in_ready !== (!out_valid || out_ready))
                $display("FAIL random_in_ready: got %b want %b", in_ready, !out_valid || out_ready);
            else n_pass++;
            if (drn) begin
                n_total++;
                if (qz.size() == 0) begin
                    $display("FAIL random_spurious: got result %h want none pending", out_z);
                end else begin
                    ez = qz.pop_front();
                    ef = qf.pop_front();
                    if (out_z !== ez || out_flags !== ef)
                        $display("FAIL random_result: got z=%h f=%b want z=%h f=%b", out_z, out_flags, ez, ef);
                    else n_pass++;
                end
            end
            held_v = out_valid && !out_ready;
            held_z = out_z;
            held_f = out_flags;
            if (acc) begin
                e = ref_mul(a, b, rm);
                qz.push_back(e[31:0]);
                qf.push_back(e[36:32]);
            end
        end
        n_total++;
        if (qz.size() != 0) $display("FAIL random_drain: got %0d pending want 0", qz.size()); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [6], vb [6], held_z; logic [1:0] vr [6];
        logic acc, drn, saw_stall, held_v; logic [36:0] e; logic [4:0] held_f;
        int sent, got, idx;
        for (int i = 0; i < 6; i++) begin
            va[i] = rnd_op(); vb[i] = rnd_op(); vr[i] = 2'($urandom_range(0, 3));
        end
        sent = 0; got = 0; saw_stall = 1'b0; held_v = 1'b0; held_z = '0; held_f = '0;
        for (int k = 0; k < 40; k++) begin
            idx = (sent < 6) ? sent : 5;
            step(sent < 6, va[idx], vb[idx], vr[idx], !(k >= 4 && k < 8), acc, drn);
            if (!in_ready) saw_stall = 1'b1;
            if (held_v) begin
                n_total++;
                if (out_valid !== 1'b1 || out_z !== held_z || out_flags !== held_f)
                    $display("FAIL bp_stall_hold: got v=%b z=%h want v=1 z=%h", out_valid, out_z, held_z);
                else n_pass++;
            end
            if (drn) begin
                n_total++;
                if (got >= 6) begin
                    $display("FAIL bp_extra: got result #%0d want only 6", got + 1);
                end else begin
                    e = ref_mul(va[got], vb[got], vr[got]);
                    if (out_z !== e[31:0] || out_flags !== e[36:32])
                        $display("FAIL bp_result[%0d]: got z=%h f=%b want z=%h f=%b",
                                 got, out_z, out_flags, e[31:0], e[36:32]);
                    else n_pass++;
                end
                got++;
            end
            held_v = out_valid && !out_ready;
            held_z = out_z;
            held_f = out_flags;
            if (acc) sent++;
        end
        n_total++; if (saw_stall !== 1'b1) $display("FAIL bp_in_ready_drop: got %b want 1", saw_stall); else n_pass++;
        n_total++; if (got != 6) $display("FAIL bp_count: got %0d want 6", got); else n_pass++;
    endtask

    task automatic test_reset_midop();
        logic acc, drn; logic [31:0] z; logic [4:0] f; int lat, nacc;
        nacc = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h40000000 + 32'(i << 20), 32'h3FC00000, 2'd0, 1'b1, acc, drn);
            if (acc) nacc++;
        end
        n_total++; if (nacc != 3) $display("FAIL midop_accepts: got %0d want 3", nacc); else n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL midop_out_valid: got %b want 0", out_valid); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        issue(32'h40400000, 32'h40000000, 2'd0, z, f, lat);
        n_total++; if (lat !== 3) $display("FAIL midop_latency: got %0d want 3", lat); else n_pass++;
        n_total++;
        if (z !== 32'h40C00000 || f !== 5'd0)
            $display("FAIL midop_result: got z=%h f=%b want z=40C00000 f=00000", z, f);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_overflow();
        test_specials();
        test_random();
        test_back_to_back();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Parametrised, pipelined IEEE-754 binary floating-point multiplier; next generation of the team's combinational fp32 multiplier.
- Adds the following:
  - generic exponent/mantissa widths
  - three-stage pipeline with valid/ready flow control
  - four run-time rounding modes
  - IEEE exception flags
- Sits between operand-issue logic and result writeback in the datapath.

Parameters:
- EXP_W, 8, exponent field width (≥4).
- MAN_W, 23, stored fraction width (≥4); defaults give binary32.
- BIAS, 2**(EXP_W-1)-1, exponent bias (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts operands this cycle.
- in_a  in  EXP_W+MAN_W+1  operand A.
- in_b  in  EXP_W+MAN_W+1  operand B.
- in_rm  in  2  rounding mode: 0 RNE, 1 RTZ, 2 RUP (+inf), 3 RDN (-inf); travels with the operands.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_z  out  EXP_W+MAN_W+1  product.
- out_flags  out  5  {invalid, divzero(always 0), overflow, underflow, inexact}.

Behaviour:
- Reset (asynchronous, rst_n low):
  - All stage valid bits clear; out_valid=0, out_z=0, out_flags=0.
  - in_ready=1 after reset releases.
  - Reset mid-operation discards all in-flight operations; no partial result ever emerges.
- Handshake:
  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
  - Global stall: advance = ~out_valid | out_ready; in_ready = advance.
  - While stalled, every stage register holds, and out_z/out_flags stay stable with out_valid high.
- Latency and throughput:
  - 3 cycles from accepted operand to out_valid; full throughput, one result per cycle.
  - Empty slots (bubbles) propagate as invalid stages.
- S1, unpack/multiply, registered at end of cycle:
  - sign = sa^sb.
  - Classify each operand as zero, inf, NaN or normal.
  - Subnormal inputs are treated as zero (DAZ).
  - Significands are {1,frac}, MAN_W+1 bits; product is 2*(MAN_W+1) bits.
  - Signed exponent = ea+eb-BIAS, EXP_W+2 bits, two's complement.
- S2, normalise:
  - If product MSB=1, take the upper MAN_W+1 bits and add 1 to the exponent; else shift left by one.
  - guard = next bit below the kept bits; sticky = OR of all remaining bits.
- S3, round/pack:
  - RNE increments when guard & (sticky | lsb).
  - RTZ never increments.
  - RUP increments when (guard|sticky) & ~sign.
  - RDN increments when (guard|sticky) & sign.
  - A rounding carry-out renormalises: shift right 1, exponent+1.
  - inexact = guard|sticky.
- Overflow (rounded exponent ≥ 2**EXP_W-1): overflow=1 and inexact=1. Result by mode:
  - RNE: signed inf.
  - RTZ: signed max-finite.
  - RUP: +inf if positive, else -max-finite.
  - RDN: -inf if negative, else +max-finite.
- Underflow (rounded exponent ≤ 0): signed zero (FTZ), underflow=1, inexact=1.
- Specials override arithmetic; no arithmetic flags are raised for them:
  - Any NaN input gives canonical qNaN: sign 0, exponent all-ones, fraction MSB 1, rest 0. invalid=1 only if an input is a signalling NaN (fraction MSB 0).
  - inf×zero gives canonical qNaN with invalid=1.
  - inf×finite gives signed inf, flags 0.
  - zero×finite gives signed zero, flags 0.
- Simultaneous input accept and output drain in one cycle is legal and loses nothing.

Decomposition:
- Shared package fp_pkg holds:
  - rounding-mode constants RM_RNE/RM_RTZ/RM_RUP/RM_RDN
  - flag bit indices
  - class encoding (ZERO, INF, QNAN, SNAN, NORM)
  - function for the canonical NaN pattern given EXP_W/MAN_W
- One sub-module, fp_round_pack (combinational, S3 logic), is reused by future adder/FMA blocks.

Test Plan:
- Basic product: RNE, 0x3FC00000 × 0x40000000 → 0x40400000, flags 0, out_valid exactly 3 cycles after accept.
- Rounding mode: 0x3F800001 × 0x3F800001 under RNE → 0x3F800002, inexact=1; same operands under RUP → 0x3F800003; under RTZ → 0x3F800002.
- Overflow: 0x7F000000 × 0x40000000 under RNE → 0x7F800000, flags overflow|inexact; under RTZ → 0x7F7FFFFF; 0xFF000000 × 0x40000000 under RUP → 0xFF7FFFFF.
- Specials and underflow:
  - 0x7F800000 × 0x00000000 → 0x7FC00000, invalid=1.
  - 0x7F800001 × 0x3F800000 → 0x7FC00000, invalid=1.
  - 0x00800000 × 0x00800000 → 0x00000000, underflow|inexact.
- Backpressure: stream 6 back-to-back operands, hold out_ready=0 for 4 cycles mid-stream → in_ready drops, out_z stable, all 6 results delivered in order, none duplicated.
- Reset mid-operation: assert rst_n=0 with 3 ops in flight → out_valid=0 immediately; after release, the first new operand's result appears 3 cycles after accept, no stale output.
